mont_modexp_ctrl: RTL and testbench

- Sequencer that computes modular exponentiation `base^exp mod m` by left-to-right square-and-multiply.
- Issues every operation to one shared Montgomery multiplier through the multiplier's `enable_p`/`done_irq_p` pulse interface.
- Operands arrive already in the Montgomery domain. An optional final multiply-by-1 converts the result back to the normal domain.
- Sits between the host/register layer and the Montgomery multiplier in the RSA-style datapath.

---
 rtl/mont_pkg.sv | 30 +++
 rtl/mont_exp_bit_iter.sv | 51 +++++
 rtl/mont_modexp_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mont_modexp_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared types for the Montgomery modular-exponentiation sequencer and its bench.
package mont_pkg;

  localparam int MONT_NBITS = 4096;
  localparam int MONT_EBITS = 4096;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SQR_ISSUE  = 3'd1,
    ST_SQR_WAIT   = 3'd2,
    ST_MUL_ISSUE  = 3'd3,
    ST_MUL_WAIT   = 3'd4,
    ST_CONV_ISSUE = 3'd5,
    ST_CONV_WAIT  = 3'd6,
    ST_FINISH     = 3'd7
  } mont_state_e;

  typedef enum logic [1:0] {
    OP_SQR  = 2'd0,
    OP_MUL  = 2'd1,
    OP_CONV = 2'd2,
    OP_NONE = 2'd3
  } mont_op_e;

  // Operation counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mont_exp_bit_iter.sv
// Exponent bit walker: latches the exponent, then steps an index from the top
// processed bit down to bit 0.
module mont_exp_bit_iter
  import mont_pkg::*;
#(
  parameter int EBITS = MONT_EBITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [EBITS-1:0]       exp,
  input  logic [$clog2(EBITS):0] exp_size,
  input  logic                   dec,
  output logic                   cur_bit,
  output logic                   last_bit
);
  localparam int IW = $clog2(EBITS);
  localparam int SW = IW + 1;

  logic [EBITS-1:0] exp_r;
  logic [IW-1:0]    idx_r;
  logic [SW-1:0]    size_cl_s;
  logic [SW-1:0]    first_s;

  // Oversized exp_size is clamped to the register width; first index is size-1.
  always_comb begin
    if (exp_size > SW'(EBITS)) begin
      size_cl_s = SW'(EBITS);
    end else begin
      size_cl_s = exp_size;
    end
    first_s = size_cl_s - SW'(1);
  end

  // Exponent and bit-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_r <= {EBITS{1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (load) begin
      exp_r <= exp;
      idx_r <= first_s[IW-1:0];
    end else if (dec && (idx_r != {IW{1'b0}})) begin
      idx_r <= idx_r - IW'(1);
    end
  end

  assign cur_bit  = exp_r[idx_r];
  assign last_bit = (idx_r == {IW{1'b0}});

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer that drives one shared
// Montgomery multiplier through its enable/done pulse handshake.
module mont_modexp_ctrl
  import mont_pkg::*;
#(
  parameter int NBITS       = MONT_NBITS,
  parameter int EBITS       = MONT_EBITS,
  parameter int CONVERT_OUT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_p,
  input  logic [NBITS-1:0]       base_m,
  input  logic [NBITS-1:0]       one_m,
  input  logic [EBITS-1:0]       exp,
  input  logic [$clog2(EBITS):0] exp_size,
  output logic                   mul_enable_p,
  output logic [NBITS-1:0]       mul_a,
  output logic [NBITS-1:0]       mul_b,
  input  logic [NBITS-1:0]       mul_y,
  input  logic                   mul_done_p,
  output logic [NBITS-1:0]       result,
  output logic                   done_irq_p,
  output logic                   busy,
  output logic [15:0]            mul_count
);
  localparam int SW = $clog2(EBITS) + 1;
  localparam mont_state_e END_ST = (CONVERT_OUT != 0) ? ST_CONV_ISSUE : ST_FINISH;

  mont_state_e      state_r;
  mont_state_e      tgt_s;
  logic [NBITS-1:0] acc_r;
  logic [NBITS-1:0] base_r;
  logic [NBITS-1:0] src_s;
  logic             load_s;
  logic             take_y_s;
  logic             dec_s;
  logic             cur_bit_s;
  logic             last_bit_s;
  logic             size_zero_s;

  mont_exp_bit_iter #(.EBITS(EBITS)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .exp      (exp),
    .exp_size (exp_size),
    .dec      (dec_s),
    .cur_bit  (cur_bit_s),
    .last_bit (last_bit_s)
  );

  assign load_s      = (state_r == ST_IDLE) && start_p;
  assign size_zero_s = (exp_size == {SW{1'b0}});

  // Next-state selection; src_s is the accumulator value the next operation uses.
  always_comb begin
    tgt_s    = state_r;
    take_y_s = 1'b0;
    dec_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_p) begin
          tgt_s = size_zero_s ? END_ST : ST_SQR_ISSUE;
        end else begin
          tgt_s = ST_IDLE;
        end
      end
      ST_SQR_ISSUE:  tgt_s = ST_SQR_WAIT;
      ST_SQR_WAIT: begin
        if (mul_done_p) begin
          take_y_s = 1'b1;
          if (cur_bit_s) begin
            tgt_s = ST_MUL_ISSUE;
          end else if (last_bit_s) begin
            tgt_s = END_ST;
          end else begin
            dec_s = 1'b1;
            tgt_s = ST_SQR_ISSUE;
          end
        end else begin
          tgt_s = ST_SQR_WAIT;
        end
      end
      ST_MUL_ISSUE:  tgt_s = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mul_done_p) begin
          take_y_s = 1'b1;
          if (last_bit_s) begin
            tgt_s = END_ST;
          end else begin
            dec_s = 1'b1;
            tgt_s = ST_SQR_ISSUE;
          end
        end else begin
          tgt_s = ST_MUL_WAIT;
        end
      end
      ST_CONV_ISSUE: tgt_s = ST_CONV_WAIT;
      ST_CONV_WAIT: begin
        if (mul_done_p) begin
          take_y_s = 1'b1;
          tgt_s    = ST_FINISH;
        end else begin
          tgt_s = ST_CONV_WAIT;
        end
      end
      ST_FINISH:     tgt_s = ST_IDLE;
      default:       tgt_s = ST_IDLE;
    endcase
    if (load_s) begin
      src_s = one_m;
    end else if (take_y_s) begin
      src_s = mul_y;
    end else begin
      src_s = acc_r;
    end
  end

  // State register and registered outputs; pulses and operands are set on
  // entry to an ISSUE/FINISH state so they are visible during that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      acc_r        <= {NBITS{1'b0}};
      base_r       <= {NBITS{1'b0}};
      mul_enable_p <= 1'b0;
      mul_a        <= {NBITS{1'b0}};
      mul_b        <= {NBITS{1'b0}};
      result       <= {NBITS{1'b0}};
      done_irq_p   <= 1'b0;
      busy         <= 1'b0;
      mul_count    <= 16'd0;
    end else begin
      state_r      <= tgt_s;
      mul_enable_p <= 1'b0;
      done_irq_p   <= 1'b0;
      if (load_s || take_y_s) begin
        acc_r <= src_s;
      end
      if (load_s) begin
        base_r    <= base_m;
        mul_count <= 16'd0;
        busy      <= 1'b1;
      end
      if ((state_r == ST_SQR_ISSUE) || (state_r == ST_MUL_ISSUE) ||
          (state_r == ST_CONV_ISSUE)) begin
        mul_count <= sat_inc16(mul_count);
      end
      if (state_r == ST_FINISH) begin
        busy <= 1'b0;
      end
      if (tgt_s != state_r) begin
        case (tgt_s)
          ST_SQR_ISSUE: begin
            mul_enable_p <= 1'b1;
            mul_a        <= src_s;
            mul_b        <= src_s;
          end
          ST_MUL_ISSUE: begin
            mul_enable_p <= 1'b1;
            mul_a        <= src_s;
            mul_b        <= base_r;
          end
          ST_CONV_ISSUE: begin
            mul_enable_p <= 1'b1;
            mul_a        <= src_s;
            mul_b        <= NBITS'(1);
          end
          ST_FINISH: begin
            result     <= src_s;
            done_irq_p <= 1'b1;
          end
          default: begin
            mul_enable_p <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Scoreboard bench: m=241, R=256, behavioural multiplier y = a*b*R^-1 mod m.
module tb_mont_modexp_ctrl;
  import mont_pkg::*;

  localparam int NB   = 8;
  localparam int EB   = 8;
  localparam int SW   = $clog2(EB) + 1;
  localparam int MOD  = 241;
  localparam int RINV = 225;   // 256 * 225 = 1 mod 241
  localparam logic [NB-1:0] ONE_M = 8'd15;

  typedef struct { mont_op_e op; logic [NB-1:0] a; logic [NB-1:0] b; } op_t;
  typedef struct { logic [NB-1:0] res; int cnt; int lat; } fin_t;

  logic clk = 1'b0;
  logic rst;
  logic start_p;
  logic [NB-1:0] base_m, one_m;
  logic [EB-1:0] exp;
  logic [SW-1:0] exp_size;
  logic mul_enable_p, mul_done_p, done_irq_p, busy;
  logic [NB-1:0] mul_a, mul_b, mul_y, result;
  logic [15:0] mul_count;
  logic mul_enable_p0, mul_done_p0, done_irq_p0, busy0;
  logic [NB-1:0] mul_a0, mul_b0, mul_y0, result0;
  logic [15:0] mul_count0;

  logic mdl_done, mdl0_done, spur_done;
  logic [NB-1:0] mdl_y, mdl0_y, held_a, held_b;
  int mdl_cnt, mdl0_cnt;
  int ncmp = 0, nmis = 0, cyc = 0, start_cyc = 0, mul_lat = 5;
  op_t  op_q[$];
  fin_t fin_q[$];
  fin_t fin0_q[$];

  mont_modexp_ctrl #(.NBITS(NB), .EBITS(EB), .CONVERT_OUT(1)) u_dut (
    .clk(clk), .rst(rst), .start_p(start_p), .base_m(base_m), .one_m(one_m),
    .exp(exp), .exp_size(exp_size), .mul_enable_p(mul_enable_p), .mul_a(mul_a),
    .mul_b(mul_b), .mul_y(mul_y), .mul_done_p(mul_done_p), .result(result),
    .done_irq_p(done_irq_p), .busy(busy), .mul_count(mul_count));

  mont_modexp_ctrl #(.NBITS(NB), .EBITS(EB), .CONVERT_OUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start_p(start_p), .base_m(base_m), .one_m(one_m),
    .exp(exp), .exp_size(exp_size), .mul_enable_p(mul_enable_p0), .mul_a(mul_a0),
    .mul_b(mul_b0), .mul_y(mul_y0), .mul_done_p(mul_done_p0), .result(result0),
    .done_irq_p(done_irq_p0), .busy(busy0), .mul_count(mul_count0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NB-1:0] mm(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int unsigned p;
    p = (32'(a) * 32'(b)) % MOD;
    p = (p * RINV) % MOD;
    return p[NB-1:0];
  endfunction

  // Multiplier models: done arrives mul_lat cycles after the enable cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_cnt <= 0; mdl_done <= 1'b0; mdl_y <= 8'd0;
    end else begin
      mdl_done <= 1'b0;
      if (mul_enable_p) begin
        mdl_y <= mm(mul_a, mul_b); mdl_cnt <= mul_lat - 1;
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) mdl_done <= 1'b1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl0_cnt <= 0; mdl0_done <= 1'b0; mdl0_y <= 8'd0;
    end else begin
      mdl0_done <= 1'b0;
      if (mul_enable_p0) begin
        mdl0_y <= mm(mul_a0, mul_b0); mdl0_cnt <= mul_lat - 1;
      end else if (mdl0_cnt != 0) begin
        mdl0_cnt <= mdl0_cnt - 1;
        if (mdl0_cnt == 1) mdl0_done <= 1'b1;
      end
    end
  end

  assign mul_done_p  = mdl_done | spur_done;
  assign mul_y       = mdl_y;
  assign mul_done_p0 = mdl0_done;
  assign mul_y0      = mdl0_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic mis(input string name, input logic [31:0] act, input logic [31:0] expv);
    ncmp++; nmis++;
    $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic mon_issue();
    op_t e;
    if (op_q.size() == 0) begin
      mis("issue_unexpected", 32'(mul_a), 32'(0));
    end else begin
      e = op_q.pop_front();
      chk($sformatf("%s_mul_a", e.op.name()), 32'(mul_a), 32'(e.a));
      chk($sformatf("%s_mul_b", e.op.name()), 32'(mul_b), 32'(e.b));
    end
  endtask

  task automatic mon_fin(input bit conv);
    fin_t f;
    if (conv) begin
      if (fin_q.size() == 0) begin
        mis("done_unexpected", 32'(result), 32'(0));
      end else begin
        f = fin_q.pop_front();
        chk("result", 32'(result), 32'(f.res));
        chk("mul_count", 32'(mul_count), 32'(f.cnt));
        chk("done_latency", 32'(cyc - start_cyc), 32'(f.lat));
        chk("busy_at_done", 32'(busy), 32'(1));
      end
    end else begin
      if (fin0_q.size() == 0) begin
        mis("c0_done_unexpected", 32'(result0), 32'(0));
      end else begin
        f = fin0_q.pop_front();
        chk("c0_result", 32'(result0), 32'(f.res));
        chk("c0_mul_count", 32'(mul_count0), 32'(f.cnt));
        chk("c0_done_latency", 32'(cyc - start_cyc), 32'(f.lat));
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUTs present an output event.
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_enable_p) begin
        held_a <= mul_a;
        held_b <= mul_b;
        mon_issue();
      end
      if (mdl_done) begin
        chk("stable_mul_a", 32'(mul_a), 32'(held_a));
        chk("stable_mul_b", 32'(mul_b), 32'(held_b));
      end
      if (done_irq_p)  mon_fin(1'b1);
      if (done_irq_p0) mon_fin(1'b0);
    end
  end

  task automatic push_op(input mont_op_e op, input logic [NB-1:0] a, input logic [NB-1:0] b);
    op_t o;
    o.op = op; o.a = a; o.b = b;
    op_q.push_back(o);
  endtask

  task automatic push_fin(input bit conv, input logic [NB-1:0] res, input int cnt);
    fin_t f;
    f.res = res; f.cnt = cnt; f.lat = cnt * (mul_lat + 1) + 1;
    if (conv) fin_q.push_back(f);
    else      fin0_q.push_back(f);
  endtask

  // Issue one run; res1/res0 and cnt are hand-computed for the two DUT variants.
  task automatic run(input logic [NB-1:0] bm, input logic [EB-1:0] e, input logic [SW-1:0] sz,
                     input logic [NB-1:0] res1, input logic [NB-1:0] res0, input int cnt);
    logic [NB-1:0] acc;
    int n;
    acc = ONE_M;
    n = (int'(sz) > EB) ? EB : int'(sz);
    for (int i = n - 1; i >= 0; i--) begin
      push_op(OP_SQR, acc, acc);
      acc = mm(acc, acc);
      if (e[i]) begin
        push_op(OP_MUL, acc, bm);
        acc = mm(acc, bm);
      end
    end
    push_op(OP_CONV, acc, 8'd1);
    push_fin(1'b1, res1, cnt);
    push_fin(1'b0, res0, cnt - 1);
    base_m = bm; one_m = ONE_M; exp = e; exp_size = sz;
    start_p = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_p = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [NB-1:0] res);
    int k;
    k = 0;
    while (done_irq_p !== 1'b1 && k < 3000) begin
      @(negedge clk); k++;
    end
    if (k >= 3000) mis({name, "_timeout"}, 32'(k), 32'(0));
    @(posedge clk); #1;
    chk({name, "_busy_after"}, 32'(busy), 32'(0));
    chk({name, "_ops_drained"}, 32'(op_q.size()), 32'(0));
    chk({name, "_c0_drained"}, 32'(fin0_q.size()), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_result_held"}, 32'(result), 32'(res));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_enable"}, 32'(mul_enable_p), 32'(0));
    chk({name, "_mul_a"}, 32'(mul_a), 32'(0));
    chk({name, "_mul_b"}, 32'(mul_b), 32'(0));
    chk({name, "_result"}, 32'(result), 32'(0));
    chk({name, "_done"}, 32'(done_irq_p), 32'(0));
    chk({name, "_busy"}, 32'(busy), 32'(0));
    chk({name, "_count"}, 32'(mul_count), 32'(0));
    chk({name, "_c0_busy"}, 32'(busy0), 32'(0));
  endtask

  initial begin
    rst = 1'b1; start_p = 1'b0; spur_done = 1'b0;
    base_m = 8'd0; one_m = 8'd0; exp = 8'd0; exp_size = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 3^5 mod 241 = 2; Montgomery form 2*256 mod 241 = 30
    run(8'd45, 8'h05, 4'd4, 8'd2, 8'd30, 7);
    wait_done("pow3_5", 8'd2);

    // empty exponent with a 2-cycle multiplier: done_irq_p 4 cycles after start
    mul_lat = 2;
    run(ONE_M, 8'h00, 4'd0, 8'd1, 8'd15, 1);
    wait_done("exp_empty", 8'd1);
    mul_lat = 5;

    // 2^11 = 2048 mod 241 = 120; 120*256 mod 241 = 113
    run(8'd30, 8'h0B, 4'd4, 8'd120, 8'd113, 8);
    wait_done("pow2_11", 8'd120);

    // exp_size 15 clamps to 8 bits: seven leading zeros still squared
    run(8'd30, 8'h01, 4'd15, 8'd2, 8'd30, 10);
    wait_done("clamp", 8'd2);

    // done coincident with enable, then a start while busy: both ignored
    run(8'd45, 8'h05, 4'd4, 8'd2, 8'd30, 7);
    chk("enable_first_cycle", 32'(mul_enable_p), 32'(1));
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    base_m = 8'd30; exp = 8'hFF; exp_size = 4'd8; start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    wait_done("restart_ignored", 8'd2);

    // spurious done in IDLE
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_spur_busy", 32'(busy), 32'(0));
    chk("idle_spur_count", 32'(mul_count), 32'(7));
    chk("idle_spur_result", 32'(result), 32'(2));

    // reset while waiting on the first MUL (third operation)
    run(8'd45, 8'h05, 4'd4, 8'd2, 8'd30, 7);
    repeat (12) @(posedge clk);
    #1;
    chk("mul_issue_enable", 32'(mul_enable_p), 32'(1));
    chk("mul_issue_b", 32'(mul_b), 32'(45));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("abort");
    op_q.delete(); fin_q.delete(); fin0_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(8'd30, 8'h0B, 4'd4, 8'd120, 8'd113, 8);
    wait_done("after_abort", 8'd120);

    chk("final_fin_drained", 32'(fin_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
